uart_image_receiver: RTL
========================

# uart_image_receiver

Receive-side counterpart of the UART image sender. Consumes bytes from the Uart8 receive interface, locks onto a frame sync byte, reassembles 10-bit pixels from byte pairs and writes them sequentially into the frame buffer write port (SDRAM write FIFO). It sits between Uart8 (`rx*` signals) and the SDRAM write side, and reports frame completion and errors for HEX/LED debug.

## Interface
- WIDTH, 10, pixels per line
- HEIGHT, 1, lines per frame; frame = WIDTH*HEIGHT pixels
- ADDR_W, 20, width of the pixel address output
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000000, max clk cycles between bytes inside a frame (about 19 byte times at 9600 baud, 50 MHz)
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; 1 = arm/keep receiving, 0 = abort to IDLE
- rxEn  out  1  enable to Uart8 receiver
- rx_data  in  8  received byte (Uart8 `out`)
- rxDone  in  1  byte-complete flag; rising edge = new byte
- rxErr  in  1  UART framing error flag
- sdram_wr_data  out  10  pixel value
- sdram_wr_addr  out  ADDR_W  pixel index within frame
- sdram_wr_load  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse, frame accepted
- frame_err  out  1  one-cycle pulse, frame aborted on error
- err_code  out  2  last error: 0 none, 1 UART framing, 2 timeout, 3 format/checksum
- state  out  3  current FSM state, for HEX display

## Operation
- Reset: all outputs 0; `rxDone` edge register 0; pixel counter 0; state IDLE (0).
- Byte event = `rxDone`==1 while its previous-cycle registered value was 0. A held `rxDone` yields exactly one event.
- States: IDLE(0), SYNC(1), LO(2), HI(3), WRITE(4), CHECK(5), DONE(6), ERR(7).
- IDLE: `rxEn`=0. `en`=1 → SYNC next cycle, pixel counter cleared.
- SYNC: `rxEn`=1. Byte == SYNC_BYTE → LO. Other bytes are ignored. No timeout in this state.
- LO: byte event → latch low byte, go to HI.
- HI: byte event → if `rx_data[7:2]`≠0 → ERR (code 3); else pixel = {rx_data[1:0], low}, go to WRITE.
- WRITE: single cycle. Drive `sdram_wr_load`=1, `sdram_wr_data`=pixel, `sdram_wr_addr`=counter. Counter increments. If counter was WIDTH*HEIGHT-1 → CHECK (macro on) or DONE (macro off); else → LO.
- DONE: `frame_done`=1 for one cycle, `err_code`←0, → SYNC if `en`=1, otherwise IDLE.
- ERR: `frame_err`=1 for one cycle, `err_code` holds cause, → SYNC if `en`=1, otherwise IDLE. Already-written pixels are not retracted.
- `rxErr` sampled 1 in LO, HI or CHECK → ERR (code 1), taking priority over a same-cycle byte event.
- Timeout counter resets on entry to LO and on every byte event. In LO, HI and CHECK, reaching TIMEOUT_CYCLES → ERR (code 2). Priority: rxErr > byte event > timeout.
- `en`=0 in any state except DONE/ERR → IDLE next cycle, no pulse, `err_code` unchanged.
- `err_code` persists until the next DONE or ERR.
- Counter arithmetic: ADDR_W bits, cleared on SYNC entry, never wraps within a frame. WIDTH*HEIGHT ≤ 2^ADDR_W.

## Timing
- Let cycle N be the first cycle with `rxDone`=1. The event is detected in N, the state transitions at N+1, and the HI byte event produces `sdram_wr_load`=1 in N+1 (WRITE state).
- `sdram_wr_data` and `sdram_wr_addr` are valid only while `sdram_wr_load`=1; they hold their last values otherwise.
- The minimum inter-byte gap the FSM tolerates is 2 cycles. UART byte spacing (~52k cycles) is far larger.
- `frame_done` and `frame_err` are registered, one cycle wide, and mutually exclusive.
- Reset assertion mid-frame forces reset values immediately, asynchronously. A strobe in progress is dropped.

## Configuration
- `UART_RX_CHECKSUM_EN` defined: after the last pixel the FSM waits in CHECK for one byte equal to the XOR of all LO/HI data bytes in the frame (sync byte excluded). Match → DONE. Mismatch → ERR code 3. The running XOR is cleared on SYNC entry.
- Not defined: the CHECK state and XOR register are absent. The last WRITE → DONE. State 5 is unreachable.

## Test plan
- WIDTH=2, HEIGHT=1, macro off, en=1; bytes A5,34,01,FF,03 → writes (addr0,0x134) then (addr1,0x3FF), one `frame_done`, `err_code`=0, `state` returns to 1.
- Bytes 00,5A,A5,10,00,20,00 → leading 00/5A ignored; writes 0x010, 0x020; `frame_done`.
- A5,10,04 → HI byte upper bits nonzero; no write, `frame_err`, `err_code`=3.
- A5,10 then silence for TIMEOUT_CYCLES (override to 100) → `frame_err`, `err_code`=2; a following A5 frame completes normally.
- `rxErr` pulsed together with `rxDone` in HI → `frame_err`, code 1, no write. Separately, `rst_n` low mid-frame → all outputs 0, state 0.
- Macro on: A5,34,01,FF,03,C9 → `frame_done` (XOR 34^01^FF^03 = C9); trailing C8 → `frame_err`, code 3.

Source files
------------

// File: rtl/uart_image_receiver.sv
// ============================================================================
// Module  : uart_image_receiver
// Brief   : Locks onto a UART frame sync byte, rebuilds 10-bit pixels from
//           byte pairs and streams them to the frame buffer write port.
//           Optional trailing XOR checksum byte: define UART_RX_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_image_receiver #(
   parameter int         WIDTH          = 10,
   parameter int         HEIGHT         = 1,
   parameter int         ADDR_W         = 20,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rxEn,
   input  logic [7:0]        rx_data,
   input  logic              rxDone,
   input  logic              rxErr,
   output logic [9:0]        sdram_wr_data,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic              sdram_wr_load,
   output logic              frame_done,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic [2:0]        state
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_sync  = 3'd1;
   localparam logic [2:0] c_st_lo    = 3'd2;
   localparam logic [2:0] c_st_hi    = 3'd3;
   localparam logic [2:0] c_st_write = 3'd4;
   localparam logic [2:0] c_st_check = 3'd5;
   localparam logic [2:0] c_st_done  = 3'd6;
   localparam logic [2:0] c_st_err   = 3'd7;

   localparam logic [1:0] c_err_uart    = 2'd1;
   localparam logic [1:0] c_err_timeout = 2'd2;
   localparam logic [1:0] c_err_format  = 2'd3;

   localparam int                c_to_w     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] c_pix_last = ADDR_W'(WIDTH * HEIGHT - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [1:0]        w_cause;
   logic              r_rx_done_d;
   logic              w_byte_ev;
   logic              w_timeout;
   logic [7:0]        r_lo;
   logic [ADDR_W-1:0] r_pix_cnt;
   logic [c_to_w-1:0] r_to_cnt;
   logic [9:0]        r_wr_data;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [1:0]        r_err_code;
`ifdef UART_RX_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   assign w_byte_ev = rxDone & ~r_rx_done_d;
   assign w_timeout = (r_to_cnt == c_to_last);

   always_comb begin
      w_next  = r_state;
      w_cause = r_err_code;
      case (r_state)
         c_st_idle: if (en) w_next = c_st_sync;
         c_st_sync: if (w_byte_ev && rx_data == SYNC_BYTE) w_next = c_st_lo;
         c_st_lo: begin
            if (rxErr) begin
               w_next = c_st_err; w_cause = c_err_uart;
            end else if (w_byte_ev) begin
               w_next = c_st_hi;
            end else if (w_timeout) begin
               w_next = c_st_err; w_cause = c_err_timeout;
            end
         end
         c_st_hi: begin
            if (rxErr) begin
               w_next = c_st_err; w_cause = c_err_uart;
            end else if (w_byte_ev) begin
               if (rx_data[7:2] != 6'd0) begin
                  w_next = c_st_err; w_cause = c_err_format;
               end else begin
                  w_next = c_st_write;
               end
            end else if (w_timeout) begin
               w_next = c_st_err; w_cause = c_err_timeout;
            end
         end
`ifdef UART_RX_CHECKSUM_EN
         c_st_write: w_next = (r_pix_cnt == c_pix_last) ? c_st_check : c_st_lo;
         c_st_check: begin
            if (rxErr) begin
               w_next = c_st_err; w_cause = c_err_uart;
            end else if (w_byte_ev) begin
               if (rx_data == r_xor) begin
                  w_next = c_st_done;
               end else begin
                  w_next = c_st_err; w_cause = c_err_format;
               end
            end else if (w_timeout) begin
               w_next = c_st_err; w_cause = c_err_timeout;
            end
         end
`else
         c_st_write: w_next = (r_pix_cnt == c_pix_last) ? c_st_done : c_st_lo;
`endif
         c_st_done, c_st_err: w_next = en ? c_st_sync : c_st_idle;
         default: w_next = c_st_idle;
      endcase
      // Dropping en aborts silently everywhere except the reporting states.
      if (!en && r_state != c_st_done && r_state != c_st_err) w_next = c_st_idle;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_st_idle;
         r_rx_done_d <= 1'b0;
         r_lo        <= 8'd0;
         r_pix_cnt   <= '0;
         r_to_cnt    <= '0;
         r_wr_data   <= 10'd0;
         r_wr_addr   <= '0;
         r_err_code  <= 2'd0;
`ifdef UART_RX_CHECKSUM_EN
         r_xor       <= 8'd0;
`endif
      end else begin
         r_state     <= w_next;
         r_rx_done_d <= rxDone;

         if (w_next == c_st_sync && r_state != c_st_sync) begin
            r_pix_cnt <= '0;
`ifdef UART_RX_CHECKSUM_EN
            r_xor     <= 8'd0;
`endif
         end else if (r_state == c_st_write) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
         end

`ifdef UART_RX_CHECKSUM_EN
         if ((r_state == c_st_lo || r_state == c_st_hi) && w_byte_ev)
            r_xor <= r_xor ^ rx_data;
`endif

         if (r_state == c_st_lo && w_byte_ev) r_lo <= rx_data;

         // Capture the write beat so data/addr hold once the strobe drops.
         if (r_state == c_st_hi && w_next == c_st_write) begin
            r_wr_data <= {rx_data[1:0], r_lo};
            r_wr_addr <= r_pix_cnt;
         end

         if ((w_next == c_st_lo && r_state != c_st_lo) || w_byte_ev)
            r_to_cnt <= '0;
         else if (r_state == c_st_lo || r_state == c_st_hi || r_state == c_st_check)
            r_to_cnt <= r_to_cnt + 1'b1;

         if (w_next == c_st_err) r_err_code <= w_cause;
         else if (r_state == c_st_done) r_err_code <= 2'd0;
      end
   end

   assign state         = r_state;
   assign rxEn          = (r_state != c_st_idle);
   assign sdram_wr_load = (r_state == c_st_write);
   assign sdram_wr_data = r_wr_data;
   assign sdram_wr_addr = r_wr_addr;
   assign frame_done    = (r_state == c_st_done);
   assign frame_err     = (r_state == c_st_err);
   assign err_code      = r_err_code;

endmodule

`default_nettype wire
